// File: rtl/uart_echo_responder.sv
`default_nettype none
// ============================================================================
// Module   : uart_echo_responder
// Purpose  : Queues bytes from uart_rx (XOR-transformed) and echoes them to
//            uart_tx, with overflow and parity-error tracking.
// Revision : 1.0 - initial release
// ============================================================================
module uart_echo_responder #(
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     drop_invalid,
    input  logic [7:0]               xor_mask,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    input  logic                     rx_new,
    input  logic                     tx_ready,
    output logic [7:0]               tx_data,
    output logic                     tx_send,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [7:0]               perr_count,
    output logic                     busy
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_tw = $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_aw:0] c_full = (c_aw + 1)'(DEPTH);
    localparam logic [c_tw:0] c_tmo  = (c_tw + 1)'(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              in_push_q, in_push_d;
    logic              in_bad_q, in_bad_d;
    logic [7:0]        in_byte_q, in_byte_d;
    logic [c_aw-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_aw-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_aw:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        perr_q, perr_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [c_tw-1:0]   tmo_q, tmo_d;
    logic [7:0]        fifo_mem_q [DEPTH];

    logic              w_full;
    logic              w_pop;
    logic              w_wr_en;
    logic [c_tw:0]     w_tmo_next;

    always_comb begin
        // uart_rx outputs are registered once before entering the FIFO
        in_push_d  = rx_new & en & (rx_valid | ~drop_invalid);
        in_bad_d   = rx_new & ~rx_valid;
        in_byte_d  = rx_data ^ xor_mask;

        w_full     = (count_q == c_full);
        w_pop      = (state_q == ST_IDLE) && (count_q != '0) && tx_ready;
        w_wr_en    = in_push_q && (!w_full || w_pop);

        wr_ptr_d   = w_wr_en ? wr_ptr_q + c_aw'(1) : wr_ptr_q;
        rd_ptr_d   = w_pop   ? rd_ptr_q + c_aw'(1) : rd_ptr_q;
        case ({w_wr_en, w_pop})
            2'b10:   count_d = count_q + (c_aw + 1)'(1);
            2'b01:   count_d = count_q - (c_aw + 1)'(1);
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q | (in_push_q & w_full & ~w_pop);
        perr_d     = perr_q;
        if (in_bad_q && (perr_q != 8'hFF)) begin
            perr_d = perr_q + 8'd1;
        end

        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tmo_d      = tmo_q;
        w_tmo_next = {1'b0, tmo_q} + (c_tw + 1)'(1);
        case (state_q)
            ST_IDLE: begin
                if (w_pop) begin
                    tx_data_d = fifo_mem_q[rd_ptr_q];
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                tmo_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                // No acknowledge from uart_tx within the window: re-strobe
                if (!tx_ready) begin
                    state_d = ST_WAIT_DONE;
                end else if (w_tmo_next == c_tmo) begin
                    state_d = ST_SEND;
                end else begin
                    tmo_d = w_tmo_next[c_tw-1:0];
                end
            end
            ST_WAIT_DONE: begin
                if (tx_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            in_push_q  <= 1'b0;
            in_bad_q   <= 1'b0;
            in_byte_q  <= 8'h00;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            perr_q     <= 8'h00;
            tx_data_q  <= 8'h00;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            in_push_q  <= in_push_d;
            in_bad_q   <= in_bad_d;
            in_byte_q  <= in_byte_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            perr_q     <= perr_d;
            tx_data_q  <= tx_data_d;
            tmo_q      <= tmo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            fifo_mem_q[wr_ptr_q] <= in_byte_q;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_send    = (state_q == ST_SEND);
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign perr_count = perr_q;
    assign busy       = (state_q != ST_IDLE) || (count_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_uart_echo_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_echo_responder
// Purpose  : Self-checking bench: queue-based reference model, uart_tx
//            emulator, directed scenarios and a randomized phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_echo_responder;

    localparam int DEPTH  = 8;
    localparam int ACK_TO = 4;

    logic       clk = 1'b0;
    logic       rst, en, drop_invalid, rx_valid, rx_new;
    logic [7:0] xor_mask, rx_data;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_send;
    logic [$clog2(DEPTH):0] fifo_count;
    logic       overflow;
    logic [7:0] perr_count;
    logic       busy;

    uart_echo_responder #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TO)) dut (
        .clk(clk), .rst(rst), .en(en), .drop_invalid(drop_invalid),
        .xor_mask(xor_mask), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_new(rx_new), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx_send(tx_send), .fifo_count(fifo_count), .overflow(overflow),
        .perr_count(perr_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // uart_tx emulator: after each strobe it stays busy for tx_lat cycles
    logic tx_mode = 1'b1;
    logic tx_hold = 1'b1;
    int   tx_lat  = 3;
    int   emu_cnt = 0;
    int   n_sends = 0;
    assign tx_ready = tx_mode ? (emu_cnt == 0) : tx_hold;
    always @(negedge clk) begin
        if (tx_send === 1'b1) begin
            emu_cnt = tx_lat;
            n_sends++;
        end else if (emu_cnt > 0) begin
            emu_cnt--;
        end
    end

    // Reference model: byte queue plus transfer phase
    // (0 idle, 1 strobe, 2 awaiting ack, 3 awaiting completion)
    logic [7:0] mq [$];
    int         m_phase = 0, m_tmo = 0, m_perr = 0;
    logic [7:0] m_txd = 8'h00, s_byte = 8'h00, m_head;
    logic       m_ovf = 1'b0, s_push = 1'b0, s_bad = 1'b0, m_pop, m_full;
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_phase = 0; m_tmo = 0; m_perr = 0; m_txd = 8'h00;
            m_ovf = 1'b0; s_push = 1'b0; s_bad = 1'b0; s_byte = 8'h00;
        end else begin
            m_full = (mq.size() == DEPTH);
            m_pop  = (m_phase == 0) && (mq.size() > 0) && tx_ready;
            m_head = 8'h00;
            if (m_pop) m_head = mq.pop_front();
            if (s_push) begin
                if (!m_full || m_pop) mq.push_back(s_byte);
                else m_ovf = 1'b1;
            end
            if (s_bad && m_perr < 255) m_perr++;
            case (m_phase)
                0: if (m_pop) begin m_txd = m_head; m_phase = 1; end
                1: begin m_tmo = 0; m_phase = 2; end
                2: if (!tx_ready) m_phase = 3;
                   else if (m_tmo + 1 == ACK_TO) m_phase = 1;
                   else m_tmo++;
                default: if (tx_ready) m_phase = 0;
            endcase
            s_push = rx_new && en && (rx_valid || !drop_invalid);
            s_bad  = rx_new && !rx_valid;
            s_byte = rx_data ^ xor_mask;
        end
    end

    logic chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_tx_send",  32'(tx_send),    32'(m_phase == 1));
            chk("m_tx_data",  32'(tx_data),    32'(m_txd));
            chk("m_count",    32'(fifo_count), 32'(mq.size()));
            chk("m_overflow", 32'(overflow),   32'(m_ovf));
            chk("m_perr",     32'(perr_count), 32'(m_perr));
            chk("m_busy",     32'(busy),       32'((m_phase != 0) || (mq.size() != 0)));
        end
    end

    task automatic pulse(input logic [7:0] d, input logic v);
        rx_data = d; rx_valid = v; rx_new = 1'b1;
        @(negedge clk);
        rx_new = 1'b0; rx_valid = 1'b1;
    endtask

    task automatic wait_send(output logic [7:0] d);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (tx_send !== 1'b1 && k < 400);
        chk("wait_send_timeout", 32'(tx_send), 32'd1);
        d = tx_data;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic [7:0] exp_b;
        int lat, s0;
        rst = 1'b1; en = 1'b1; drop_invalid = 1'b0; xor_mask = 8'h00;
        rx_data = 8'h00; rx_valid = 1'b1; rx_new = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_send", 32'(tx_send), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single echo with a slow uart_tx
        tx_lat = 100;
        s0 = n_sends;
        pulse(8'hA5, 1'b1);
        lat = 1;
        while (tx_send !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        chk("echo_latency", 32'(lat), 32'd3);
        chk("echo_data", 32'(tx_data), 32'hA5);
        repeat (50) @(negedge clk);
        chk("echo_busy_mid", 32'(busy), 32'd1);
        repeat (60) @(negedge clk);
        chk("echo_busy_done", 32'(busy), 32'd0);
        chk("echo_count", 32'(fifo_count), 32'd0);
        chk("echo_once", 32'(n_sends - s0), 32'd1);

        // Transform and ordering
        tx_mode = 1'b0; tx_hold = 1'b0; xor_mask = 8'h20;
        pulse(8'h41, 1'b1); pulse(8'h42, 1'b1); pulse(8'h43, 1'b1);
        xor_mask = 8'h00;
        @(negedge clk);
        chk("xor_count3", 32'(fifo_count), 32'd3);
        tx_lat = 4; tx_mode = 1'b1;
        wait_send(b); chk("xor_b0", 32'(b), 32'h61);
        wait_send(b); chk("xor_b1", 32'(b), 32'h62);
        wait_send(b); chk("xor_b2", 32'(b), 32'h63);
        repeat (20) @(negedge clk);

        // Overflow, then simultaneous push/pop while full
        tx_mode = 1'b0; tx_hold = 1'b0; tx_lat = 3;
        for (int i = 0; i < 9; i++) pulse(8'h10 + 8'(i), 1'b1);
        @(negedge clk);
        chk("ovf_count", 32'(fifo_count), 32'd8);
        chk("ovf_flag", 32'(overflow), 32'd1);
        pulse(8'h19, 1'b1);
        tx_mode = 1'b1;
        @(negedge clk);
        chk("ovf_pushpop_count", 32'(fifo_count), 32'd8);
        chk("ovf_first_send", 32'(tx_send), 32'd1);
        chk("ovf_b0", 32'(tx_data), 32'h10);
        for (int i = 1; i < 9; i++) begin
            wait_send(b);
            exp_b = (i < 8) ? 8'h10 + 8'(i) : 8'h19;
            chk("ovf_stream", 32'(b), 32'(exp_b));
        end
        chk("ovf_sticky", 32'(overflow), 32'd1);
        repeat (10) @(negedge clk);

        // Parity handling and saturation
        drop_invalid = 1'b1;
        s0 = n_sends;
        pulse(8'h33, 1'b0);
        repeat (4) @(negedge clk);
        chk("par_perr1", 32'(perr_count), 32'd1);
        chk("par_dropped", 32'(n_sends - s0), 32'd0);
        chk("par_count0", 32'(fifo_count), 32'd0);
        drop_invalid = 1'b0;
        pulse(8'h33, 1'b0);
        wait_send(b);
        chk("par_echo", 32'(b), 32'h33);
        chk("par_perr2", 32'(perr_count), 32'd2);
        drop_invalid = 1'b1;
        for (int i = 0; i < 300; i++) pulse(8'(i), 1'b0);
        repeat (3) @(negedge clk);
        chk("par_saturate", 32'(perr_count), 32'd255);
        drop_invalid = 1'b0;

        // Timeout retry with uart_tx never acknowledging
        tx_mode = 1'b0; tx_hold = 1'b1;
        pulse(8'h5A, 1'b1); pulse(8'h5B, 1'b1);
        wait_send(b);
        chk("retry_first", 32'(b), 32'h5A);
        lat = 0;
        do begin @(negedge clk); lat++; end while (tx_send !== 1'b1 && lat < 20);
        chk("retry_gap", 32'(lat), 32'd5);
        chk("retry_data", 32'(tx_data), 32'h5A);
        chk("retry_no_pop", 32'(fifo_count), 32'd1);
        tx_mode = 1'b1; tx_lat = 3;
        repeat (40) @(negedge clk);

        // Reset while a transfer is outstanding
        tx_lat = 50;
        for (int i = 0; i < 4; i++) pulse(8'h70 + 8'(i), 1'b1);
        repeat (10) @(negedge clk);
        chk("rstmid_count3", 32'(fifo_count), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_send", 32'(tx_send), 32'd0);
        chk("rstmid_data", 32'(tx_data), 32'd0);
        chk("rstmid_count", 32'(fifo_count), 32'd0);
        chk("rstmid_ovf", 32'(overflow), 32'd0);
        chk("rstmid_perr", 32'(perr_count), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tx_lat = 3;
        repeat (60) @(negedge clk);

        // Receiver disabled: nothing queued, parity still counted
        en = 1'b0;
        pulse(8'h11, 1'b1); pulse(8'h22, 1'b0); pulse(8'h33, 1'b1);
        pulse(8'h44, 1'b0); pulse(8'h55, 1'b0);
        repeat (3) @(negedge clk);
        chk("en0_count", 32'(fifo_count), 32'd0);
        chk("en0_perr", 32'(perr_count), 32'd3);
        chk("en0_busy", 32'(busy), 32'd0);
        en = 1'b1;

        // Randomized traffic against the model
        for (int c = 0; c < 2500; c++) begin
            rst          = ($urandom_range(0, 399) == 0);
            en           = ($urandom_range(0, 9) != 0);
            drop_invalid = 1'($urandom_range(0, 1));
            if (c % 64 == 0) begin
                xor_mask = 8'($urandom);
                tx_mode  = ($urandom_range(0, 3) != 0);
                tx_hold  = 1'($urandom_range(0, 1));
                tx_lat   = $urandom_range(1, 8);
            end
            rx_new   = ($urandom_range(0, 2) == 0);
            rx_data  = 8'($urandom);
            rx_valid = ($urandom_range(0, 4) != 0);
            @(negedge clk);
        end
        rst = 1'b0; rx_new = 1'b0; tx_mode = 1'b1; tx_lat = 3;
        repeat (300) @(negedge clk);
        chk("final_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_echo_responder.md
Name: uart_echo_responder

Overview:
- Far-end responder for the UART test board. Connects to a uart_rx byte interface and a uart_tx byte interface.
- Buffers each received byte in a small FIFO and retransmits it, optionally XOR-transformed, so the board sees an echo of every byte it sends.
- Tracks parity errors and FIFO overflow for display on LEDs/SSD.

Parameters:
- DEPTH, 8, FIFO depth in bytes; power of 2, at least 2.
- ACK_TIMEOUT, 255, clk cycles to wait for tx_ready to fall after a send pulse before re-pulsing send.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  1 = accept new received bytes; 0 = ignore incoming bytes (FIFO still drains).
- drop_invalid  in  1  1 = discard bytes whose parity check failed.
- xor_mask  in  8  applied to each byte at push (tx byte = rx byte ^ xor_mask).
- rx_data  in  8  received byte from uart_rx.
- rx_valid  in  1  parity-ok flag from uart_rx; qualified only by rx_new.
- rx_new  in  1  one-cycle pulse: rx_data/rx_valid are new.
- tx_ready  in  1  uart_tx idle flag.
- tx_data  out  8  byte presented to uart_tx.
- tx_send  out  1  one-cycle send strobe to uart_tx.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky flag: a byte was lost because the FIFO was full.
- perr_count  out  8  saturating count of rx_new pulses with rx_valid=0.
- busy  out  1  high when the TX FSM is not in IDLE or fifo_count is non-zero.

Behaviour:
- Reset state: FIFO empty, pointers 0, FSM IDLE, tx_data=0, tx_send=0, overflow=0, perr_count=0, fifo_count=0.
- Push condition: rx_new & en & (rx_valid | ~drop_invalid). Pushed value = rx_data ^ xor_mask, with xor_mask sampled in the same cycle.
- perr_count: increments on rx_new & ~rx_valid regardless of en or drop_invalid. Saturates at 255.
- Full FIFO: a push while full with no same-cycle pop is dropped and overflow is set to 1. overflow is cleared only by rst.
- Push and pop in the same cycle: both take effect, including when the FIFO is full (no overflow) and when it is non-empty. Push into an empty FIFO is not visible to pop until the next cycle.
- Pointers wrap modulo DEPTH. fifo_count is updated registered, one cycle after the event.
- TX FSM states:
  - IDLE: if FIFO non-empty and tx_ready=1, pop the head into tx_data and go to SEND.
  - SEND: tx_send=1 for exactly this cycle; reset the timeout counter; go to WAIT_BUSY.
  - WAIT_BUSY: if tx_ready=0, go to WAIT_DONE. Otherwise, when the counter reaches ACK_TIMEOUT, go to SEND (re-strobe with the same tx_data, no new pop).
  - WAIT_DONE: when tx_ready=1, go to IDLE.
- Latency: a byte pushed into an empty FIFO with tx_ready=1 produces tx_send 3 cycles after its rx_new pulse (push, IDLE pop, SEND).
- tx_data is stable from the pop until the next pop.
- tx_send is never asserted while tx_ready=0 in IDLE. At most one byte is in flight at a time.
- en=0 mid-transfer: the current transfer and all queued bytes still complete.
- rst mid-transfer: everything returns to reset values next cycle and tx_send deasserts immediately. Queued bytes are lost.

Test Plan:
- Single echo: xor_mask=0x00, rx_new with rx_data=0xA5, rx_valid=1, tx_ready=1 → tx_send pulses exactly once 3 cycles later with tx_data=0xA5. Model tx_ready low for 100 cycles → busy=1 until the FSM returns to IDLE, fifo_count back to 0.
- Transform and ordering: xor_mask=0x20, push 0x41, 0x42, 0x43 back-to-back while tx_ready=0 → fifo_count=3. Release tx_ready → tx_data 0x61, 0x62, 0x63 in order, one tx_send each.
- Overflow: DEPTH=8, tx_ready=0, 9 pushes → fifo_count=8, overflow=1, the 9th byte is absent from the echoed stream. Then push and pop in the same cycle while full → count stays 8, no new loss.
- Parity: drop_invalid=1, rx_valid=0 on 0x33 → no push, perr_count=1. With drop_invalid=0 the same stimulus → pushed and echoed, perr_count=2. 300 bad bytes → perr_count saturates at 255.
- Timeout retry: ACK_TIMEOUT=4, tx_ready held 1 after tx_send → a second tx_send with the same tx_data exactly 5 cycles after the first, and no extra pop.
- Reset/enable: assert rst while in WAIT_DONE with 3 bytes queued → next cycle all outputs at reset values. Separately, en=0 with rx_new pulses → no pushes, but perr_count still counts invalid bytes.
